multicycle_alu: RTL and testbench

Parametrised, registered successor to the single-cycle combinational ALU. It adds a start/done handshake, registered result and condition flags, and iterative unsigned multiply, divide and remainder. It sits between the operand muxes (RA, RB or immediate) and the RZ/CCR registers. The control unit issues one operation at a time and stalls while Busy is high.

---
 rtl/multicycle_alu.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_alu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Registered ALU with a start/done handshake. Most ops finish in one cycle.
// MULU/DIVU/REMU take WIDTH iterations on a shared hi/lo accumulator pair.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int OPW   = 7
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [OPW-1:0]   ALU_Op,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  input  logic             CarryIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] RZ,
  output logic             NEGATIVE_FLAG,
  output logic             ZERO_FLAG,
  output logic             OVERFLOW_FLAG,
  output logic             CARRY_FLAG,
  output logic             INR_FLAG
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [1:0] K_ALU = 2'd0;
  localparam logic [1:0] K_NOP = 2'd1;
  localparam logic [1:0] K_BAD = 2'd2;

  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [OPW-1:0] OP_MULU = OPW'(19);
  localparam logic [OPW-1:0] OP_DIVU = OPW'(20);
  localparam logic [OPW-1:0] OP_REMU = OPW'(21);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;
  // Multiply: {hi,lo} is the shifting product, lo starts as the multiplier.
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : '0)};
  assign div_shift = {hi_q, lo_q[MSB]};
  assign div_diff  = div_shift - {1'b0, b_q};

  logic [WIDTH-1:0] res;
  logic             res_c, res_v;
  logic [1:0]       kind;
  logic [WIDTH:0]   add_s;
  logic [WIDTH-1:0] sub_d;

  assign add_s = {1'b0, a_q} + {1'b0, b_q};
  assign sub_d = a_q - b_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    kind  = K_ALU;
    case (op_q)
      OPW'(0), OPW'(16), OPW'(17), OPW'(18), OPW'(64), OPW'(65): kind = K_NOP;
      OPW'(1), OPW'(14), OPW'(34), OPW'(44), OPW'(45): begin
        res   = add_s[MSB:0];
        res_c = add_s[WIDTH];
        res_v = (a_q[MSB] == b_q[MSB]) && (add_s[MSB] != a_q[MSB]);
      end
      OPW'(2), OPW'(35), OPW'(39), OPW'(40), OPW'(41): begin
        res   = sub_d;
        res_c = a_q < b_q;
        res_v = (a_q[MSB] != b_q[MSB]) && (sub_d[MSB] != a_q[MSB]);
      end
      OPW'(3), OPW'(36): res = a_q & b_q;
      OPW'(4), OPW'(37): res = a_q | b_q;
      OPW'(6), OPW'(38): res = a_q ^ b_q;
      OPW'(7):           res = ~a_q;
      OPW'(5):           res = -a_q;
      OPW'(13):          res = a_q;
      OPW'(15), OPW'(32), OPW'(33), OPW'(42), OPW'(43): res = b_q;
      OPW'(8):  begin res = a_q >> 1;                    res_c = a_q[0];   end
      OPW'(9):  begin res = {a_q[MSB], a_q[MSB:1]};      res_c = a_q[0];   end
      OPW'(10): begin res = {a_q[MSB-1:0], 1'b0};        res_c = a_q[MSB]; end
      OPW'(11): begin res = {cin_q, a_q[MSB:1]};         res_c = a_q[0];   end
      OPW'(12): begin res = {a_q[MSB-1:0], cin_q};       res_c = a_q[MSB]; end
      OP_MULU:  begin res = lo_q;                        res_c = |hi_q;    end
      // Divide by zero never iterates; it is resolved here from the latched operands.
      OP_DIVU: begin
        res   = (b_q == '0) ? '1 : lo_q;
        res_v = (b_q == '0);
      end
      OP_REMU: begin
        res   = (b_q == '0) ? a_q : hi_q;
        res_v = (b_q == '0);
      end
      default: kind = K_BAD;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= S_IDLE;
      count         <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      cin_q         <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      RZ            <= '0;
      NEGATIVE_FLAG <= 1'b0;
      ZERO_FLAG     <= 1'b0;
      OVERFLOW_FLAG <= 1'b0;
      CARRY_FLAG    <= 1'b0;
      INR_FLAG      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      Done <= 1'b0;
      // Registered so Busy covers exactly the WIDTH iteration edges.
      Busy <= (state == S_ITER);
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_q  <= ALU_Op;
            a_q   <= RA;
            b_q   <= RB;
            cin_q <= CarryIn;
            hi_q  <= '0;
            lo_q  <= (ALU_Op == OP_MULU) ? RB : RA;
            if (ALU_Op == OP_MULU ||
                ((ALU_Op == OP_DIVU || ALU_Op == OP_REMU) && RB != '0)) begin
              state <= S_ITER;
              count <= CW'(WIDTH - 1);
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_ITER: begin
          if (op_q == OP_MULU) begin
            {hi_q, lo_q} <= {mul_sum, lo_q[MSB:1]};
          end else if (!div_diff[WIDTH]) begin
            hi_q <= div_diff[MSB:0];
            lo_q <= {lo_q[MSB-1:0], 1'b1};
          end else begin
            hi_q <= div_shift[MSB:0];
            lo_q <= {lo_q[MSB-1:0], 1'b0};
          end
          count <= count - 1'b1;
          if (count == '0) state <= S_FIN;
        end
        S_FIN: begin
          Done  <= 1'b1;
          RZ    <= res;
          state <= S_IDLE;
          case (kind)
            K_NOP: INR_FLAG <= 1'b0;
            K_BAD: INR_FLAG <= 1'b1;
            default: begin
              NEGATIVE_FLAG <= res[MSB];
              ZERO_FLAG     <= (res == '0);
              OVERFLOW_FLAG <= res_v;
              CARRY_FLAG    <= res_c;
              INR_FLAG      <= 1'b0;
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed scenarios then random ops
// compared against an arithmetic reference model of the ALU.
module tb_multicycle_alu;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [6:0]  ALU_Op;
  logic [31:0] RA, RB;
  logic        CarryIn;
  logic        Busy, Done;
  logic [31:0] RZ;
  logic        NEGATIVE_FLAG, ZERO_FLAG, OVERFLOW_FLAG, CARRY_FLAG, INR_FLAG;

  multicycle_alu #(.WIDTH(32), .OPW(7)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .ALU_Op(ALU_Op),
    .RA(RA), .RB(RB), .CarryIn(CarryIn), .Busy(Busy), .Done(Done), .RZ(RZ),
    .NEGATIVE_FLAG(NEGATIVE_FLAG), .ZERO_FLAG(ZERO_FLAG),
    .OVERFLOW_FLAG(OVERFLOW_FLAG), .CARRY_FLAG(CARRY_FLAG), .INR_FLAG(INR_FLAG)
  );

  always #5 Clock = ~Clock;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_rz;
  logic [4:0]  exp_f;   // {N, Z, V, C, INR}
  int          exp_lat;

  function automatic logic [4:0] flags_now();
    return {NEGATIVE_FLAG, ZERO_FLAG, OVERFLOW_FLAG, CARRY_FLAG, INR_FLAG};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result, flags and latency straight from the operation table.
  task automatic model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin);
    int          code;
    logic [32:0] s;
    logic [63:0] p;
    logic [31:0] r;
    logic        v, c, known;
    code    = int'(op);
    r       = '0;
    v       = 1'b0;
    c       = 1'b0;
    known   = 1'b1;
    exp_lat = 1;
    if (code inside {0, 16, 17, 18, 64, 65}) begin
      exp_rz   = '0;
      exp_f[0] = 1'b0;
      return;
    end
    if (code inside {1, 14, 34, 44, 45}) begin
      s = {1'b0, a} + {1'b0, b};
      r = s[31:0];
      c = s[32];
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (code inside {2, 35, 39, 40, 41}) begin
      r = a - b;
      c = (a < b);
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end else if (code inside {3, 36}) r = a & b;
    else if (code inside {4, 37}) r = a | b;
    else if (code inside {6, 38}) r = a ^ b;
    else if (code == 7) r = ~a;
    else if (code == 5) r = 32'd0 - a;
    else if (code == 13) r = a;
    else if (code inside {15, 32, 33, 42, 43}) r = b;
    else if (code == 8)  begin r = a >> 1; c = a[0]; end
    else if (code == 9)  begin r = (a >> 1) | (a & 32'h8000_0000); c = a[0]; end
    else if (code == 10) begin r = a << 1; c = a[31]; end
    else if (code == 11) begin r = (a >> 1) | ({31'd0, cin} << 31); c = a[0]; end
    else if (code == 12) begin r = (a << 1) | {31'd0, cin}; c = a[31]; end
    else if (code == 19) begin
      p = {32'd0, a} * {32'd0, b};
      r = p[31:0];
      c = (p[63:32] != 0);
      exp_lat = 33;
    end else if (code == 20 || code == 21) begin
      if (b == 0) begin
        r = (code == 20) ? 32'hFFFF_FFFF : a;
        v = 1'b1;
      end else begin
        r = (code == 20) ? a / b : a % b;
        exp_lat = 33;
      end
    end else known = 1'b0;
    if (known) begin
      exp_rz = r;
      exp_f  = {r[31], (r == 0), v, c, 1'b0};
    end else begin
      exp_rz   = '0;
      exp_f[0] = 1'b1;
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the Done cycle.
  task automatic do_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input bit glitch, input string tag);
    int          lat, busy;
    logic [31:0] prev;
    prev = exp_rz;
    model(op, a, b, cin);
    ALU_Op  = op;
    RA      = a;
    RB      = b;
    CarryIn = cin;
    Start   = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start   = 1'b0;
    RA      = $urandom;
    RB      = $urandom;
    CarryIn = 1'($urandom);
    ALU_Op  = 7'($urandom);
    check({tag, " rz_hold"}, 64'(RZ), 64'(prev));
    lat  = 0;
    busy = 0;
    do begin
      @(posedge Clock);
      lat++;
      @(negedge Clock);
      if (Busy) busy++;
      if (glitch && lat == 5) begin
        Start  = 1'b1;
        ALU_Op = 7'd1;
      end else if (glitch && lat == 6) begin
        Start = 1'b0;
      end
    end while (!Done && lat < 100);
    Start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy_cycles"}, 64'(busy), 64'((exp_lat == 33) ? 32 : 0));
    check({tag, " rz"}, 64'(RZ), 64'(exp_rz));
    check({tag, " flags"}, 64'(flags_now()), 64'(exp_f));
  endtask

  initial begin
    int dn;
    logic [6:0]  op;
    logic [31:0] a, b;

    Reset = 1'b1; Start = 1'b0; ALU_Op = '0; RA = '0; RB = '0; CarryIn = 1'b0;
    exp_rz = '0; exp_f = '0; exp_lat = 1;
    repeat (2) @(negedge Clock);
    check("reset rz", 64'(RZ), 64'd0);
    check("reset flags", 64'(flags_now()), 64'd0);
    check("reset busy", 64'(Busy), 64'd0);
    check("reset done", 64'(Done), 64'd0);
    Reset = 1'b0;
    @(negedge Clock);

    // Abort a MULU with an asynchronous reset between clock edges.
    do_op(7'd1, 32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0, "add_pre");
    ALU_Op = 7'd19; RA = 32'd5; RB = 32'd7; Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    check("mid busy", 64'(Busy), 64'd1);
    #2 Reset = 1'b1;
    #1;
    check("abort rz", 64'(RZ), 64'd0);
    check("abort flags", 64'(flags_now()), 64'd0);
    check("abort busy", 64'(Busy), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    exp_rz = '0;
    exp_f  = '0;
    dn = 0;
    repeat (40) begin
      @(negedge Clock);
      if (Done) dn++;
    end
    check("abort no_done", 64'(dn), 64'd0);

    do_op(7'd1, 32'd2, 32'd3, 1'b0, 1'b0, "add_2_3");
    do_op(7'd1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "add_ovf");
    do_op(7'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "add_carry");
    do_op(7'd2, 32'd3, 32'd5, 1'b0, 1'b0, "sub_3_5");
    do_op(7'd11, 32'h0000_0001, 32'd0, 1'b1, 1'b0, "ror");
    do_op(7'd19, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, "mulu");
    dn = 0;
    repeat (3) begin
      @(negedge Clock);
      if (Done) dn++;
    end
    check("mulu ignored_start", 64'(dn), 64'd0);
    do_op(7'd20, 32'd100, 32'd7, 1'b0, 1'b0, "divu");
    do_op(7'd21, 32'd100, 32'd7, 1'b0, 1'b0, "remu");
    do_op(7'd20, 32'd100, 32'd0, 1'b0, 1'b0, "divu_zero");
    do_op(7'd21, 32'd100, 32'd0, 1'b0, 1'b0, "remu_zero");
    do_op(7'd2, 32'd3, 32'd5, 1'b0, 1'b0, "sub_preset_n");
    do_op(7'd63, 32'd9, 32'd9, 1'b0, 1'b0, "op63");
    check("op63 n_held", 64'(NEGATIVE_FLAG), 64'd1);
    check("op63 inr", 64'(INR_FLAG), 64'd1);
    do_op(7'd0, 32'd9, 32'd9, 1'b0, 1'b0, "op0");
    check("op0 inr", 64'(INR_FLAG), 64'd0);

    // Back-to-back random ops, biased towards the iterative ones.
    for (int i = 0; i < 40; i++) begin
      op = 7'($urandom_range(0, 70));
      if ($urandom_range(0, 3) == 0) op = 7'(19 + $urandom_range(0, 2));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      do_op(op, a, b, 1'($urandom), 1'b0, $sformatf("rand%0d_op%0d", i, op));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
